// File: rtl/reg_file_sb.sv
// Register file with N combinational read ports, one write port, optional zero
// register and write-to-read bypass, plus a busy-bit scoreboard for RAW stalls.
module reg_file_sb #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] READ_ADDR,
    output logic [NUM_READ*DATA_WIDTH-1:0] READ_DATA,
    output logic [NUM_READ-1:0]            READ_READY,
    input  logic                           WRITE_ENABLE,
    input  logic [ADDR_WIDTH-1:0]          WRITE_ADDR,
    input  logic [DATA_WIDTH-1:0]          WRITE_DATA,
    input  logic                           RESERVE_ENABLE,
    input  logic [ADDR_WIDTH-1:0]          RESERVE_ADDR,
    output logic [ADDR_WIDTH:0]            BUSY_COUNT
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;
    logic                  wr_ok;
    logic                  rs_ok;
    logic                  set_new;
    logic                  clr_old;
    logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ];

    // Reserve beats write on the same register, so the count only moves when
    // a bit actually flips.
    always_comb begin
        wr_ok    = WRITE_ENABLE && !(ZERO_REG && (WRITE_ADDR == '0));
        rs_ok    = RESERVE_ENABLE && !(ZERO_REG && (RESERVE_ADDR == '0));
        set_new  = rs_ok && !busy[RESERVE_ADDR];
        clr_old  = wr_ok && busy[WRITE_ADDR] && !(rs_ok && (RESERVE_ADDR == WRITE_ADDR));
        busy_nxt = busy;
        if (wr_ok) busy_nxt[WRITE_ADDR] = 1'b0;
        if (rs_ok) busy_nxt[RESERVE_ADDR] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
            busy       <= '0;
            BUSY_COUNT <= '0;
        end else begin
            if (wr_ok) regs[WRITE_ADDR] <= WRITE_DATA;
            busy       <= busy_nxt;
            BUSY_COUNT <= BUSY_COUNT + CW'(set_new) - CW'(clr_old);
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd_addr
        assign rd_addr[g] = READ_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    always_comb begin
        READ_DATA  = '0;
        READ_READY = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (RESET) begin
                READ_DATA[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                READ_READY[i]                         = 1'b0;
            end else if (ZERO_REG && (rd_addr[i] == '0)) begin
                READ_DATA[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                READ_READY[i]                         = 1'b1;
            end else if (BYPASS && WRITE_ENABLE && (WRITE_ADDR == rd_addr[i])) begin
                READ_DATA[i*DATA_WIDTH +: DATA_WIDTH] = WRITE_DATA;
                READ_READY[i]                         = 1'b1;
            end else begin
                READ_DATA[i*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr[i]];
                READ_READY[i]                         = !busy[rd_addr[i]];
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: a bypass and a non-bypass instance share stimulus; an
// array/queue reference model predicts reads and busy count each cycle.
module tb_reg_file_sb;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR*AW-1:0] raddr;
    logic          we, re;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [NR*DW-1:0] rdata_b, rdata_n;
    logic [NR-1:0] rrdy_b, rrdy_n;
    logic [AW:0]   cnt_b, cnt_n;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
        .CLK(clk), .RESET(rst), .READ_ADDR(raddr), .READ_DATA(rdata_b), .READ_READY(rrdy_b),
        .WRITE_ENABLE(we), .WRITE_ADDR(wa), .WRITE_DATA(wd),
        .RESERVE_ENABLE(re), .RESERVE_ADDR(ra), .BUSY_COUNT(cnt_b));

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
        .CLK(clk), .RESET(rst), .READ_ADDR(raddr), .READ_DATA(rdata_n), .READ_READY(rrdy_n),
        .WRITE_ENABLE(we), .WRITE_ADDR(wa), .WRITE_DATA(wd),
        .RESERVE_ENABLE(re), .RESERVE_ADDR(ra), .BUSY_COUNT(cnt_n));

    typedef struct {
        logic [NR*DW-1:0] d_b;
        logic [NR-1:0]    r_b;
        logic [NR*DW-1:0] d_n;
        logic [NR-1:0]    r_n;
        logic [AW:0]      cnt;
    } exp_t;

    exp_t   sb_q[$];
    int     total = 0;
    int     bad = 0;
    int     pushed = 0;
    int     popped = 0;

    logic [DW-1:0] mem [32];
    bit            busy_m [32];
    bit            model_ok = 0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle once a prediction is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                popped++;
                for (int p = 0; p < NR; p++) begin
                    check($sformatf("byp_data%0d", p), rdata_b[p*DW +: DW], e.d_b[p*DW +: DW]);
                    check($sformatf("byp_rdy%0d", p), DW'(rrdy_b[p]), DW'(e.r_b[p]));
                    check($sformatf("nob_data%0d", p), rdata_n[p*DW +: DW], e.d_n[p*DW +: DW]);
                    check($sformatf("nob_rdy%0d", p), DW'(rrdy_n[p]), DW'(e.r_n[p]));
                end
                check("byp_count", DW'(cnt_b), DW'(e.cnt));
                check("nob_count", DW'(cnt_n), DW'(e.cnt));
            end
        end
    end

    // Predict this cycle's outputs from the model, then advance the model past the edge.
    task automatic step();
        exp_t e;
        int   n;
        logic [AW-1:0] a;
        if (model_ok) begin
            n = 0;
            for (int r = 0; r < 32; r++) n += busy_m[r] ? 1 : 0;
            e.cnt = (AW+1)'(n);
            for (int p = 0; p < NR; p++) begin
                a = raddr[p*AW +: AW];
                if (rst) begin
                    e.d_b[p*DW +: DW] = '0; e.r_b[p] = 1'b0;
                    e.d_n[p*DW +: DW] = '0; e.r_n[p] = 1'b0;
                end else if (a == 0) begin
                    e.d_b[p*DW +: DW] = '0; e.r_b[p] = 1'b1;
                    e.d_n[p*DW +: DW] = '0; e.r_n[p] = 1'b1;
                end else begin
                    e.d_n[p*DW +: DW] = mem[a]; e.r_n[p] = !busy_m[a];
                    if (we && wa == a) begin
                        e.d_b[p*DW +: DW] = wd; e.r_b[p] = 1'b1;
                    end else begin
                        e.d_b[p*DW +: DW] = mem[a]; e.r_b[p] = !busy_m[a];
                    end
                end
            end
            sb_q.push_back(e);
            pushed++;
        end
        if (rst) begin
            for (int r = 0; r < 32; r++) begin mem[r] = '0; busy_m[r] = 0; end
            model_ok = 1;
        end else begin
            if (we && wa != 0) mem[wa] = wd;
            if (we) busy_m[wa] = 0;
            if (re && ra != 0) busy_m[ra] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic w, input logic [AW-1:0] wad, input logic [DW-1:0] wdat,
                       input logic rs, input logic [AW-1:0] rsa, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rst = r; we = w; wa = wad; wd = wdat; re = rs; ra = rsa; raddr = {a1, a0};
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; we = 0; re = 0; wa = '0; ra = '0; wd = '0; raddr = '0;
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 4, 64'h77, 1, 6, 4, 6);
        // 1: clean state, zero register immune to writes
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 0, 0, AW'(i), AW'(31 - i));
        cyc(0, 1, 0, 64'hFFFF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // 2: reserve then retire with bypass
        cyc(0, 0, 0, 0, 1, 5, 5, 5);
        cyc(0, 0, 0, 0, 0, 0, 5, 5);
        cyc(0, 1, 5, 64'hDEADBEEF, 0, 0, 5, 5);
        cyc(0, 0, 0, 0, 0, 0, 5, 5);
        // 3: reserve and write same register in one edge
        cyc(0, 1, 7, 64'h1234, 1, 7, 7, 0);
        cyc(0, 0, 0, 0, 0, 0, 7, 7);
        // 4: set one, clear another
        cyc(0, 0, 0, 0, 1, 3, 3, 4);
        cyc(0, 1, 3, 64'h33, 1, 4, 3, 4);
        cyc(0, 0, 0, 0, 0, 0, 3, 4);
        cyc(0, 1, 7, 64'h71, 0, 0, 7, 4);
        cyc(0, 1, 4, 64'h44, 0, 0, 4, 7);
        // 5: write-cycle read of r9
        cyc(0, 1, 9, 64'hAA, 0, 0, 9, 9);
        cyc(0, 0, 0, 0, 0, 0, 9, 9);
        // 6: reset mid-reservation drops busy bits and the write
        for (int i = 1; i <= 6; i++) cyc(0, 0, 0, 0, 1, AW'(i), AW'(i), 2);
        cyc(1, 1, 2, 64'h55, 1, 7, 2, 1);
        for (int i = 8; i <= 10; i++) cyc(0, 0, 0, 0, 1, AW'(i), 2, AW'(i - 7));
        cyc(0, 0, 0, 0, 0, 0, 2, 10);
        // random traffic, biased so reads often hit the write/reserve addresses
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] w_a, r_a, a0, a1;
            w_a = AW'($urandom_range(0, 31));
            r_a = ($urandom_range(0, 3) == 0) ? w_a : AW'($urandom_range(0, 31));
            a0  = ($urandom_range(0, 2) == 0) ? w_a : AW'($urandom_range(0, 31));
            a1  = ($urandom_range(0, 3) == 0) ? a0 : (($urandom_range(0, 2) == 0) ? r_a : AW'($urandom_range(0, 31)));
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), w_a, {$urandom, $urandom},
                ($urandom_range(0, 1) == 0), r_a, a0, a1);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("scoreboard_drained", DW'(popped), DW'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
